uart_rx: RTL

- 8N1 UART receiver, LSB-first; the counterpart to the existing UART transmitter.
- Oversamples the asynchronous `rx` line on the system clock, validates the start bit and samples each bit at mid-point.
- Checks stop bit(s) and presents received bytes on a valid/ack holding register for downstream consumers (command parser, debug sink).

---
 rtl/uart_rx_if.sv | 29 ++
 rtl/uart_rx.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/uart_rx_if.sv
// Byte-side handshake bundle of the UART receiver: holding register, valid/ack and status flags.
// parityError exists only when UART_RX_PARITY_EN is defined.
interface uart_rx_if;
    logic [7:0] wordOut;
    logic       wordValid;
    logic       wordAck;
    logic       frameError;
    logic       overrun;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parityError;
`endif

    modport master (
        input  wordAck,
        output wordOut, wordValid, frameError, overrun, busy
`ifdef UART_RX_PARITY_EN
        , output parityError
`endif
    );

    modport slave (
        output wordAck,
        input  wordOut, wordValid, frameError, overrun, busy
`ifdef UART_RX_PARITY_EN
        , input parityError
`endif
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, stop-bit check and a valid/ack holding register.
// Define UART_RX_PARITY_EN to expect an even-parity bit after bit 7 and add parityError.
module uart_rx #(
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      rx,
    uart_rx_if.master bus
);
    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] HALF_CNT  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(OVERSAMPLE - 1);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd3;
    localparam logic [2:0] S_BREAK  = 3'd4;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd5;
`endif

    logic             rx_meta_reg;
    logic             rxs_reg;
    logic [2:0]       state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [2:0]       bit_idx_reg;
    logic             stop_idx_reg;
    logic [7:0]       shift_reg;
    logic             commit_reg;
    logic             frame_error_reg;
    logic [7:0]       word_reg;
    logic             valid_reg;
    logic             overrun_reg;
    logic             commit_ok;
    logic             sample_tick;

    assign sample_tick = (cnt_reg == FULL_CNT);

`ifdef UART_RX_PARITY_EN
    logic parity_bad_reg;
    logic parity_error_reg;
    assign commit_ok       = commit_reg && !parity_bad_reg;
    assign bus.parityError = parity_error_reg;
`else
    assign commit_ok = commit_reg;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_reg     <= 1'b1;
            rxs_reg         <= 1'b1;
            state_reg       <= S_IDLE;
            cnt_reg         <= '0;
            bit_idx_reg     <= '0;
            stop_idx_reg    <= 1'b0;
            shift_reg       <= '0;
            commit_reg      <= 1'b0;
            frame_error_reg <= 1'b0;
            word_reg        <= '0;
            valid_reg       <= 1'b0;
            overrun_reg     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bad_reg   <= 1'b0;
            parity_error_reg <= 1'b0;
`endif
        end else begin
            rx_meta_reg     <= rx;
            rxs_reg         <= rx_meta_reg;
            commit_reg      <= 1'b0;
            frame_error_reg <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_error_reg <= commit_reg && parity_bad_reg;
`endif
            case (state_reg)
                S_IDLE: begin
                    if (!rxs_reg) begin
                        state_reg <= S_START;
                        cnt_reg   <= '0;
                    end
                end
                S_START: begin
                    // Half a bit in: a line that is high again was only a glitch.
                    if (cnt_reg == HALF_CNT) begin
                        cnt_reg     <= '0;
                        bit_idx_reg <= '0;
                        state_reg   <= rxs_reg ? S_IDLE : S_DATA;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (sample_tick) begin
                        cnt_reg     <= '0;
                        shift_reg   <= {rxs_reg, shift_reg[7:1]};
                        bit_idx_reg <= bit_idx_reg + 3'd1;
                        if (bit_idx_reg == 3'd7) begin
                            stop_idx_reg <= 1'b0;
`ifdef UART_RX_PARITY_EN
                            state_reg    <= S_PARITY;
`else
                            state_reg    <= S_STOP;
`endif
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (sample_tick) begin
                        cnt_reg        <= '0;
                        parity_bad_reg <= rxs_reg ^ (^shift_reg);
                        state_reg      <= S_STOP;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
`endif
                S_STOP: begin
                    // Leaving at the mid-point of the last stop bit lets the next start bit in.
                    if (sample_tick) begin
                        cnt_reg <= '0;
                        if (!rxs_reg) begin
                            frame_error_reg <= 1'b1;
                            state_reg       <= S_BREAK;
                        end else if (stop_idx_reg == LAST_STOP) begin
                            commit_reg <= 1'b1;
                            state_reg  <= S_IDLE;
                        end else begin
                            stop_idx_reg <= stop_idx_reg + 1'b1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                S_BREAK: begin
                    if (rxs_reg) state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase

            // An ack in the commit cycle frees the register for the new byte.
            if (commit_ok) begin
                if (!valid_reg || bus.wordAck) begin
                    word_reg    <= shift_reg;
                    valid_reg   <= 1'b1;
                    overrun_reg <= 1'b0;
                end else begin
                    overrun_reg <= 1'b1;
                end
            end else if (bus.wordAck && valid_reg) begin
                valid_reg   <= 1'b0;
                overrun_reg <= 1'b0;
            end
        end
    end

    assign bus.wordOut    = word_reg;
    assign bus.wordValid  = valid_reg;
    assign bus.frameError = frame_error_reg;
    assign bus.overrun    = overrun_reg;
    assign bus.busy       = (state_reg != S_IDLE);
endmodule
